// File: rtl/point_add_ld_param.sv
// rtl/point_add_ld_param.sv - Lopez-Dahab mixed point adder over GF(2^M) on a shared multiplier port
// P (projective) + Q (affine) in 13 multiply slots; P=O, P=Q and P=-Q leave early.
module point_add_ld_param #(
  parameter int M        = 571,
  parameter int MULT_LAT = 3,
  parameter bit A_IS_ONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] X0,
  input  logic [M-1:0] Y0,
  input  logic [M-1:0] Z0,
  input  logic [M-1:0] X1,
  input  logic [M-1:0] Y1,
  output logic [M-1:0] mul_a,
  output logic [M-1:0] mul_b,
  input  logic [M-1:0] mul_c,
  output logic [M-1:0] X2,
  output logic [M-1:0] Y2,
  output logic [M-1:0] Z2,
  output logic         done,
  output logic         busy,
  output logic         inf,
  output logic         dbl_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  // ISSUE and CAPTURE each take one cycle, so WAIT only covers the remaining MULT_LAT-1.
  localparam int             CW        = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);
  localparam logic [M-1:0]   ONE       = {{(M-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [3:0]    slot_q;
  logic [CW-1:0] wait_q;
  logic [M-1:0]  x0_q, y0_q, z0_q, x1_q, y1_q;
  logic [M-1:0]  t_q, a_q, b_q, c_q, d_q, e_q, f_q, g_q;
  logic [M-1:0]  x_q, y_q, z_q;
  logic [M-1:0]  mul_a_q, mul_b_q;
  logic [M-1:0]  x2_q, y2_q, z2_q;
  logic          done_q, busy_q, inf_q, dbl_q;
  logic          pend_inf_q, pend_dbl_q;

  logic [M-1:0]  res_d, nxt_a_d, nxt_b_d;

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign X2      = x2_q;
  assign Y2      = y2_q;
  assign Z2      = z2_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign inf     = inf_q;
  assign dbl_req = dbl_q;

  // Result of the slot being captured, and the operands of the slot that follows it.
  always_comb begin
    res_d   = mul_c;
    nxt_a_d = mul_a_q;
    nxt_b_d = mul_b_q;
    case (slot_q)
      4'd1:  begin nxt_a_d = y1_q;           nxt_b_d = mul_c;                                end
      4'd2:  begin res_d = mul_c ^ y0_q;     nxt_a_d = x1_q;  nxt_b_d = z0_q;                end
      4'd3:  begin res_d = mul_c ^ x0_q;     nxt_a_d = z0_q;  nxt_b_d = mul_c ^ x0_q;        end
      4'd4:  begin nxt_a_d = b_q;            nxt_b_d = b_q;                                  end
      4'd5:  begin nxt_a_d = mul_c;          nxt_b_d = A_IS_ONE ? (c_q ^ t_q) : c_q;         end
      4'd6:  begin nxt_a_d = c_q;            nxt_b_d = c_q;                                  end
      4'd7:  begin nxt_a_d = a_q;            nxt_b_d = c_q;                                  end
      4'd8:  begin nxt_a_d = a_q;            nxt_b_d = a_q;                                  end
      4'd9:  begin res_d = mul_c ^ d_q ^ e_q; nxt_a_d = x1_q; nxt_b_d = z_q;                 end
      4'd10: begin res_d = x_q ^ mul_c;      nxt_a_d = z_q;   nxt_b_d = z_q;                 end
      4'd11: begin nxt_a_d = x1_q ^ y1_q;    nxt_b_d = mul_c;                                end
      4'd12: begin nxt_a_d = e_q ^ z_q;      nxt_b_d = f_q;                                  end
      4'd13: begin res_d = mul_c ^ g_q;                                                      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      slot_q     <= 4'd0;
      wait_q     <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      z0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      t_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      e_q        <= '0;
      f_q        <= '0;
      g_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      z2_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      inf_q      <= 1'b0;
      dbl_q      <= 1'b0;
      pend_inf_q <= 1'b0;
      pend_dbl_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // done_q is high on the done cycle; a start there is dropped.
          if (start && !done_q) begin
            x0_q       <= X0;
            y0_q       <= Y0;
            z0_q       <= Z0;
            x1_q       <= X1;
            y1_q       <= Y1;
            busy_q     <= 1'b1;
            pend_inf_q <= 1'b0;
            pend_dbl_q <= 1'b0;
            if (Z0 == '0) begin
              x_q     <= X1;
              y_q     <= Y1;
              z_q     <= ONE;
              state_q <= S_DONE;
            end else begin
              mul_a_q <= Z0;
              mul_b_q <= Z0;
              slot_q  <= 4'd1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wait_q  <= '0;
          state_q <= (MULT_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        S_CAPTURE: begin
          mul_a_q <= nxt_a_d;
          mul_b_q <= nxt_b_d;
          slot_q  <= slot_q + 4'd1;
          state_q <= S_ISSUE;
          case (slot_q)
            4'd1:  t_q <= res_d;
            4'd2:  a_q <= res_d;
            4'd3: begin
              b_q <= res_d;
              // B==0 means equal x: either the same point or its negation.
              if (res_d == '0) begin
                state_q <= S_DONE;
                y_q     <= '0;
                z_q     <= '0;
                if (a_q == '0) begin
                  x_q        <= '0;
                  pend_dbl_q <= 1'b1;
                end else begin
                  x_q        <= ONE;
                  pend_inf_q <= 1'b1;
                end
              end
            end
            4'd4:  c_q <= res_d;
            4'd6:  d_q <= res_d;
            4'd7:  z_q <= res_d;
            4'd8:  e_q <= res_d;
            4'd9:  x_q <= res_d;
            4'd10: f_q <= res_d;
            4'd12: g_q <= res_d;
            4'd13: begin
              y_q     <= res_d;
              state_q <= S_DONE;
            end
            default: ;
          endcase
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          x2_q    <= x_q;
          y2_q    <= y_q;
          z2_q    <= z_q;
          inf_q   <= pend_inf_q;
          dbl_q   <= pend_dbl_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_add_ld_param.sv
// tb/tb_point_add_ld_param.sv - bench for point_add_ld_param at MULT_LAT=3 and MULT_LAT=1
// Both builds share stimulus; results are checked against affine curve arithmetic.
module tb_point_add_ld_param;

  localparam int           M   = 571;
  localparam logic [M-1:0] RED = M'(32'h0000_0425);
  localparam logic [M-1:0] ONE = M'(1);
  localparam int           WIN = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start;
  logic [M-1:0] x0_s, y0_s, z0_s, x1_s, y1_s;
  logic [M-1:0] mul_a3, mul_b3, mul_c3, x2_3, y2_3, z2_3;
  logic [M-1:0] mul_a1, mul_b1, mul_c1, x2_1, y2_1, z2_1;
  logic         done3, busy3, inf3, dbl3;
  logic         done1, busy1, inf1, dbl1;
  logic [M-1:0] p3 [3];
  logic [M-1:0] p1;

  int n_checks = 0;
  int n_errors = 0;

  point_add_ld_param #(.M(M), .MULT_LAT(3), .A_IS_ONE(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X0(x0_s), .Y0(y0_s), .Z0(z0_s), .X1(x1_s), .Y1(y1_s),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_c(mul_c3),
    .X2(x2_3), .Y2(y2_3), .Z2(z2_3),
    .done(done3), .busy(busy3), .inf(inf3), .dbl_req(dbl3)
  );

  point_add_ld_param #(.M(M), .MULT_LAT(1), .A_IS_ONE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X0(x0_s), .Y0(y0_s), .Z0(z0_s), .X1(x1_s), .Y1(y1_s),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_c(mul_c1),
    .X2(x2_1), .Y2(y2_1), .Z2(z2_1),
    .done(done1), .busy(busy1), .inf(inf1), .dbl_req(dbl1)
  );

  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r, aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? RED : '0);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] gsq(input logic [M-1:0] a);
    return gmul(a, a);
  endfunction

  // a^(2^M-2) is the inverse in GF(2^M).
  function automatic logic [M-1:0] ginv(input logic [M-1:0] a);
    logic [M-1:0] r;
    r = a;
    for (int i = 1; i < M - 1; i++) r = gmul(gsq(r), a);
    return gsq(r);
  endfunction

  function automatic logic [M-1:0] rand_fe();
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < (M + 31) / 32; i++) v = {v[M-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [M-1:0] rand_nz();
    logic [M-1:0] v;
    v = rand_fe();
    if (v == '0) v = ONE;
    return v;
  endfunction

  // Pipelined field multipliers of the two latencies.
  always @(posedge clk) begin
    p3[0] <= gmul(mul_a3, mul_b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p1    <= gmul(mul_a1, mul_b1);
  end
  assign mul_c3 = p3[2];
  assign mul_c1 = p1;

  logic [M-1:0] xo [2], yo [2], zo [2], mo [2], mbo [2];
  logic [1:0]   dn, bz, inff, dbf;
  assign xo[0] = x2_3;   assign xo[1] = x2_1;
  assign yo[0] = y2_3;   assign yo[1] = y2_1;
  assign zo[0] = z2_3;   assign zo[1] = z2_1;
  assign mo[0] = mul_a3; assign mo[1] = mul_a1;
  assign mbo[0] = mul_b3; assign mbo[1] = mul_b1;
  assign dn   = {done1, done3};
  assign bz   = {busy1, busy3};
  assign inff = {inf1, inf3};
  assign dbf  = {dbl1, dbl3};

  int           cyc [2], ndone [2];
  logic [M-1:0] rx [2], ry [2], rz [2], ma_pre [2], mb_pre [2];
  logic         rinf [2], rdbl [2], rbusy1 [2], rbusy_dn [2], act [2];

  task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic check_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_L%0d_x2", nm, lat_of(d)), xo[d], '0);
      check($sformatf("%s_L%0d_y2", nm, lat_of(d)), yo[d], '0);
      check($sformatf("%s_L%0d_z2", nm, lat_of(d)), zo[d], '0);
      check($sformatf("%s_L%0d_mul", nm, lat_of(d)), mo[d] | mbo[d], '0);
      check($sformatf("%s_L%0d_flags", nm, lat_of(d)),
            M'({dn[d], bz[d], inff[d], dbf[d]}), '0);
    end
  endtask

  // Inputs are rescrambled every cycle after cycle 0 to show they were latched.
  task automatic run_op(input logic [M-1:0] a0, input logic [M-1:0] b0, input logic [M-1:0] c0,
                        input logic [M-1:0] a1, input logic [M-1:0] b1,
                        input bit glitch, input int rst_at);
    @(negedge clk);
    x0_s = a0; y0_s = b0; z0_s = c0; x1_s = a1; y1_s = b1;
    start = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ndone[d] = 0; cyc[d] = -1; act[d] = 1'b0;
      ma_pre[d] = mo[d]; mb_pre[d] = mbo[d];
    end
    @(posedge clk); #1;
    for (int c = 1; c <= WIN; c++) begin
      start = glitch && (c == 10);
      rst_n = (c != rst_at);
      x0_s = rand_fe(); y0_s = rand_fe(); z0_s = rand_fe(); x1_s = rand_fe(); y1_s = rand_fe();
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (mo[d] !== ma_pre[d] || mbo[d] !== mb_pre[d]) act[d] = 1'b1;
        if (c == 1) rbusy1[d] = bz[d];
        if (dn[d]) begin
          ndone[d]++;
          if (ndone[d] == 1) begin
            cyc[d] = c; rx[d] = xo[d]; ry[d] = yo[d]; rz[d] = zo[d];
            rinf[d] = inff[d]; rdbl[d] = dbf[d]; rbusy_dn[d] = bz[d];
          end
        end
      end
      if (c == rst_at) check_zero("midrst");
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic common_checks(input string nm, input int slots, input bit busy_c1);
    for (int d = 0; d < 2; d++) begin
      int L = lat_of(d);
      int exp_cyc = (slots == 0) ? 1 : slots * (L + 1) + 1;
      check($sformatf("%s_L%0d_cyc", nm, L), M'(cyc[d]), M'(exp_cyc));
      check($sformatf("%s_L%0d_ndone", nm, L), M'(ndone[d]), M'(1));
      check($sformatf("%s_L%0d_busy", nm, L), M'({rbusy1[d], rbusy_dn[d]}), M'({busy_c1, 1'b0}));
      check($sformatf("%s_L%0d_hold", nm, L), xo[d] ^ yo[d] ^ zo[d], rx[d] ^ ry[d] ^ rz[d]);
    end
  endtask

  task automatic add_case(input logic [M-1:0] zz, input bit glitch, input int rst_at, input string nm);
    logic [M-1:0] px, py, qx, qy, sx, sy, l;
    px = rand_nz();
    py = rand_fe();
    l  = px ^ gmul(py, ginv(px));
    qx = gsq(l) ^ l ^ ONE;
    qy = gsq(px) ^ gmul(l ^ ONE, qx);
    l  = gmul(py ^ qy, ginv(px ^ qx));
    sx = gsq(l) ^ l ^ px ^ qx ^ ONE;
    sy = gmul(l, px ^ sx) ^ sx ^ py;
    run_op(gmul(px, zz), gmul(py, gsq(zz)), zz, qx, qy, glitch, rst_at);
    if (rst_at != 0) begin
      for (int d = 0; d < 2; d++)
        check($sformatf("%s_L%0d_nodone", nm, lat_of(d)), M'(ndone[d]), '0);
    end else begin
      common_checks(nm, 13, 1'b1);
      for (int d = 0; d < 2; d++) begin
        int L = lat_of(d);
        check($sformatf("%s_L%0d_flags", nm, L), M'({rinf[d], rdbl[d]}), '0);
        check($sformatf("%s_L%0d_znz", nm, L), M'(rz[d] == '0), '0);
        check($sformatf("%s_L%0d_x", nm, L), rx[d], gmul(sx, rz[d]));
        check($sformatf("%s_L%0d_y", nm, L), ry[d], gmul(sy, gsq(rz[d])));
      end
    end
  endtask

  task automatic equal_x_case(input bit negate, input string nm);
    logic [M-1:0] qx, qy, zz;
    qx = rand_nz();
    qy = rand_fe();
    zz = rand_nz();
    run_op(gmul(qx, zz), gmul(negate ? (qx ^ qy) : qy, gsq(zz)), zz, qx, qy, 1'b0, 0);
    common_checks(nm, 3, 1'b1);
    for (int d = 0; d < 2; d++) begin
      int L = lat_of(d);
      check($sformatf("%s_L%0d_flags", nm, L), M'({rinf[d], rdbl[d]}), M'({negate, !negate}));
      check($sformatf("%s_L%0d_x", nm, L), rx[d], negate ? ONE : '0);
      check($sformatf("%s_L%0d_yz", nm, L), ry[d] | rz[d], '0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x0_s = '0; y0_s = '0; z0_s = '0; x1_s = '0; y1_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    add_case(M'(3), 1'b1, 0, "z3_glitch");
    add_case(rand_nz(), 1'b0, 0, "add_a");
    add_case(rand_nz(), 1'b0, 0, "add_b");

    run_op(rand_fe(), rand_fe(), '0, M'(5), M'(9), 1'b0, 0);
    common_checks("pinf", 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      int L = lat_of(d);
      check($sformatf("pinf_L%0d_x", L), rx[d], M'(5));
      check($sformatf("pinf_L%0d_y", L), ry[d], M'(9));
      check($sformatf("pinf_L%0d_z", L), rz[d], ONE);
      check($sformatf("pinf_L%0d_flags", L), M'({rinf[d], rdbl[d], act[d]}), '0);
    end

    equal_x_case(1'b0, "peq");
    equal_x_case(1'b1, "pneg");

    add_case(rand_nz(), 1'b0, 20, "rst20");
    add_case(rand_nz(), 1'b0, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
